// File: rtl/reduction_pair_scheduler.sv
// Sparse-reduction node sequencer: pairs LSP/MSP partial-sum beats (or passes dense beats),
// drives the reduction datapath and retires registered results per configured tile.
module reduction_pair_scheduler #(
   parameter int ACCUM_WIDTH = 48,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic                   cfg_sparse,
   input  logic [COUNT_WIDTH-1:0] cfg_len,
   input  logic                   abort,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ACCUM_WIDTH-1:0] in_data,
   input  logic                   in_is_msp,
   output logic [ACCUM_WIDTH-1:0] red_input_data,
   output logic [ACCUM_WIDTH-1:0] red_msp,
   output logic                   red_sparse_en,
   input  logic [ACCUM_WIDTH-1:0] red_output_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACCUM_WIDTH-1:0] out_data,
   output logic                   busy,
   output logic                   done,
   output logic                   err_protocol
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN_LSP = 2'd1,
      ST_RUN_MSP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   mode_q, mode_d;
   logic [COUNT_WIDTH-1:0] len_q, len_d;
   logic [COUNT_WIDTH-1:0] issued_q, issued_d;
   logic [COUNT_WIDTH-1:0] retired_q, retired_d;
   logic [ACCUM_WIDTH-1:0] lsp_q, lsp_d;
   logic                   out_valid_q, out_valid_d;
   logic [ACCUM_WIDTH-1:0] out_data_q, out_data_d;
   logic                   done_zero_q, done_zero_d;
   logic                   err_q, err_d;

   logic run_s;
   logic in_ready_s;
   logic in_fire_s;
   logic out_fire_s;
   logic last_retire_s;

   // Handshake qualifiers shared by the datapath drive and next-state logic
   always_comb begin
      run_s         = (state_q != ST_IDLE);
      in_ready_s    = run_s & (issued_q != len_q) & (~out_valid_q | out_ready);
      in_fire_s     = in_valid & in_ready_s;
      out_fire_s    = out_valid_q & out_ready;
      last_retire_s = run_s & ~abort & out_fire_s
                      & ((retired_q + COUNT_WIDTH'(1)) == len_q);
   end

   // Datapath drive: the held LSP joins the incoming MSP only while waiting for the MSP half
   always_comb begin
      red_sparse_en  = 1'b0;
      red_input_data = in_data;
      red_msp        = '0;
      if (state_q == ST_RUN_MSP) begin
         red_sparse_en  = mode_q;
         red_input_data = lsp_q;
         red_msp        = in_data;
      end else begin
         red_sparse_en  = 1'b0;
         red_input_data = in_data;
         red_msp        = '0;
      end
   end

   // Next-state: configuration, pairing, output slot, retirement and abort
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      len_d       = len_q;
      issued_d    = issued_q;
      retired_d   = retired_q;
      lsp_d       = lsp_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_zero_d = 1'b0;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               mode_d    = cfg_sparse;
               len_d     = cfg_len;
               issued_d  = '0;
               retired_d = '0;
               err_d     = 1'b0;
               if (cfg_len == '0) begin
                  done_zero_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  done_zero_d = 1'b0;
                  state_d     = ST_RUN_LSP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN_LSP, ST_RUN_MSP: begin
            if (abort) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               issued_d    = '0;
               retired_d   = '0;
            end else begin
               // Drain first so a same-cycle load wins the slot
               if (out_fire_s) begin
                  out_valid_d = 1'b0;
                  retired_d   = retired_q + COUNT_WIDTH'(1);
               end else begin
                  out_valid_d = out_valid_q;
               end
               if (in_fire_s) begin
                  if (!mode_q) begin
                     out_data_d  = red_output_data;
                     out_valid_d = 1'b1;
                     issued_d    = issued_q + COUNT_WIDTH'(1);
                  end else if (state_q == ST_RUN_LSP) begin
                     if (in_is_msp) begin
                        err_d = 1'b1;
                     end else begin
                        lsp_d   = in_data;
                        state_d = ST_RUN_MSP;
                     end
                  end else begin
                     if (in_is_msp) begin
                        out_data_d  = red_output_data;
                        out_valid_d = 1'b1;
                        issued_d    = issued_q + COUNT_WIDTH'(1);
                        state_d     = ST_RUN_LSP;
                     end else begin
                        err_d = 1'b1;
                        lsp_d = in_data;
                     end
                  end
               end else begin
                  lsp_d = lsp_q;
               end
               if (last_retire_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = state_d;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= 1'b0;
         len_q       <= '0;
         issued_q    <= '0;
         retired_q   <= '0;
         lsp_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_zero_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         retired_q   <= retired_d;
         lsp_q       <= lsp_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_zero_q <= done_zero_d;
         err_q       <= err_d;
      end
   end

   // Completion of the last result is reported in the cycle it is accepted
   always_comb begin
      cfg_ready    = (state_q == ST_IDLE);
      busy         = run_s;
      in_ready     = in_ready_s;
      out_valid    = out_valid_q;
      out_data     = out_data_q;
      err_protocol = err_q;
      done         = done_zero_q | last_retire_s;
   end

endmodule

// File: tb/tb_reduction_pair_scheduler.sv
// Directed self-checking bench for reduction_pair_scheduler with a behavioural adder datapath.
module tb_reduction_pair_scheduler;

   localparam int AW = 48;
   localparam int CW = 16;

   logic          clk;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_sparse;
   logic [CW-1:0] cfg_len;
   logic          abort;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_data;
   logic          in_is_msp;
   logic [AW-1:0] red_input_data;
   logic [AW-1:0] red_msp;
   logic          red_sparse_en;
   logic [AW-1:0] red_output_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic          busy;
   logic          done;
   logic          err_protocol;

   int errors = 0;
   int checks = 0;

   reduction_pair_scheduler #(.ACCUM_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_sparse      (cfg_sparse),
      .cfg_len         (cfg_len),
      .abort           (abort),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_is_msp       (in_is_msp),
      .red_input_data  (red_input_data),
      .red_msp         (red_msp),
      .red_sparse_en   (red_sparse_en),
      .red_output_data (red_output_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .busy            (busy),
      .done            (done),
      .err_protocol    (err_protocol)
   );

   // Reduction datapath: adds the MSP only when sparse_en, wrapping modulo 2^AW
   assign red_output_data = red_sparse_en ? (red_input_data + red_msp) : red_input_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_valid = 1'b0; cfg_sparse = 1'b0; cfg_len = '0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; in_is_msp = 1'b0; out_ready = 1'b0;
      tick(); tick();
      #1;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
      checks++;
      if ({busy, done, err_protocol, out_valid, in_ready, red_sparse_en} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=000000", {busy, done, err_protocol, out_valid, in_ready, red_sparse_en});
      end
      checks++;
      if (out_data !== 48'h0) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
      checks++;
      rst = 1'b0;
   endtask

   task automatic test_dense();
      tick(); cfg_valid = 1'b1; cfg_sparse = 1'b0; cfg_len = 16'd3; out_ready = 1'b1; #1;
      chk("dense_cfg_ready", {47'h0, cfg_ready}, 48'h1);
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'd5; in_is_msp = 1'b0; #1;
      chk("dense_busy", {47'h0, busy}, 48'h1);
      chk("dense_in_ready0", {47'h0, in_ready}, 48'h1);
      chk("dense_no_out_yet", {47'h0, out_valid}, 48'h0);
      tick(); in_data = 48'd7; in_is_msp = 1'b1; #1;
      chk("dense_out5_valid", {47'h0, out_valid}, 48'h1);
      chk("dense_out5", out_data, 48'd5);
      chk("dense_in_ready1", {47'h0, in_ready}, 48'h1);
      chk("dense_sparse_en", {47'h0, red_sparse_en}, 48'h0);
      tick(); in_data = 48'd9; in_is_msp = 1'b0; #1;
      chk("dense_out7", out_data, 48'd7);
      tick(); in_valid = 1'b0; #1;
      chk("dense_out9", out_data, 48'd9);
      chk("dense_done", {47'h0, done}, 48'h1);
      chk("dense_in_ready_full", {47'h0, in_ready}, 48'h0);
      tick(); #1;
      chk("dense_idle_cfg_ready", {47'h0, cfg_ready}, 48'h1);
      chk("dense_done_off", {47'h0, done}, 48'h0);
      chk("dense_out_cleared", {47'h0, out_valid}, 48'h0);
   endtask

   task automatic test_sparse_pairs();
      tick(); cfg_valid = 1'b1; cfg_sparse = 1'b1; cfg_len = 16'd2; out_ready = 1'b1;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'h10; in_is_msp = 1'b0; #1;
      chk("sp_lsp_ready", {47'h0, in_ready}, 48'h1);
      tick(); in_data = 48'h20; in_is_msp = 1'b1; #1;
      chk("sp_no_out_after_lsp", {47'h0, out_valid}, 48'h0);
      chk("sp_sparse_en", {47'h0, red_sparse_en}, 48'h1);
      chk("sp_red_input", red_input_data, 48'h10);
      chk("sp_red_msp", red_msp, 48'h20);
      tick(); in_data = 48'hFFFF_FFFF_FFFF; in_is_msp = 1'b0; #1;
      chk("sp_out30", out_data, 48'h30);
      chk("sp_out30_valid", {47'h0, out_valid}, 48'h1);
      tick(); in_data = 48'h1; in_is_msp = 1'b1; #1;
      chk("sp_drained", {47'h0, out_valid}, 48'h0);
      tick(); in_valid = 1'b0; #1;
      chk("sp_wrap", out_data, 48'h0);
      chk("sp_wrap_valid", {47'h0, out_valid}, 48'h1);
      chk("sp_done", {47'h0, done}, 48'h1);
      chk("sp_err_clear", {47'h0, err_protocol}, 48'h0);
      tick(); #1;
      chk("sp_idle", {47'h0, busy}, 48'h0);
   endtask

   task automatic test_protocol_error();
      tick(); cfg_valid = 1'b1; cfg_sparse = 1'b1; cfg_len = 16'd1; out_ready = 1'b1;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'h5; in_is_msp = 1'b1; #1;
      chk("pe_msp_ready", {47'h0, in_ready}, 48'h1);
      tick(); in_data = 48'h3; in_is_msp = 1'b0; #1;
      chk("pe_err", {47'h0, err_protocol}, 48'h1);
      chk("pe_dropped", {47'h0, out_valid}, 48'h0);
      chk("pe_still_lsp", {47'h0, red_sparse_en}, 48'h0);
      tick(); in_data = 48'h4; in_is_msp = 1'b1; #1;
      chk("pe_pair_in", red_input_data, 48'h3);
      tick(); in_valid = 1'b0; #1;
      chk("pe_out7", out_data, 48'h7);
      chk("pe_done", {47'h0, done}, 48'h1);
      tick(); #1;
      chk("pe_err_sticky", {47'h0, err_protocol}, 48'h1);
   endtask

   task automatic test_back_to_back();
      tick(); cfg_valid = 1'b1; cfg_sparse = 1'b0; cfg_len = 16'd4; out_ready = 1'b1;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'd1; in_is_msp = 1'b0;
      tick(); out_ready = 1'b0; in_data = 48'd2; #1;
      chk("bp_first", out_data, 48'd1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_stall_ready", {47'h0, in_ready}, 48'h0);
         chk("bp_held", out_data, 48'd1);
         chk("bp_held_valid", {47'h0, out_valid}, 48'h1);
         if (i < 2) begin tick(); #1; end
      end
      tick(); out_ready = 1'b1; #1;
      chk("bp_release_ready", {47'h0, in_ready}, 48'h1);
      chk("bp_still1", out_data, 48'd1);
      tick(); in_data = 48'd3; #1;
      chk("bp_out2", out_data, 48'd2);
      tick(); in_data = 48'd4; #1;
      chk("bp_out3", out_data, 48'd3);
      tick(); in_valid = 1'b0; #1;
      chk("bp_out4", out_data, 48'd4);
      chk("bp_done", {47'h0, done}, 48'h1);
      tick(); #1;
      chk("bp_idle", {47'h0, cfg_ready}, 48'h1);
   endtask

   task automatic test_abort();
      tick(); cfg_valid = 1'b1; cfg_sparse = 1'b1; cfg_len = 16'd3; out_ready = 1'b1;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'd1; in_is_msp = 1'b0;
      tick(); in_data = 48'd2; in_is_msp = 1'b1;
      tick(); in_valid = 1'b0; out_ready = 1'b0; abort = 1'b1; #1;
      chk("ab_result_pending", out_data, 48'd3);
      chk("ab_no_done_now", {47'h0, done}, 48'h0);
      tick(); abort = 1'b0; #1;
      chk("ab_busy", {47'h0, busy}, 48'h0);
      chk("ab_out_valid", {47'h0, out_valid}, 48'h0);
      chk("ab_no_done", {47'h0, done}, 48'h0);
      cfg_valid = 1'b1; cfg_sparse = 1'b1; cfg_len = 16'd1; out_ready = 1'b1;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'd10; in_is_msp = 1'b0;
      tick(); in_data = 48'd20; in_is_msp = 1'b1;
      tick(); in_valid = 1'b0; #1;
      chk("ab_new_out", out_data, 48'd30);
      chk("ab_new_done", {47'h0, done}, 48'h1);
   endtask

   task automatic test_zero_len_and_reset();
      tick(); cfg_valid = 1'b1; cfg_sparse = 1'b0; cfg_len = 16'd0; out_ready = 1'b1;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'd9; #1;
      chk("zl_done", {47'h0, done}, 48'h1);
      chk("zl_idle", {47'h0, busy}, 48'h0);
      chk("zl_in_ready", {47'h0, in_ready}, 48'h0);
      tick(); #1;
      chk("zl_done_once", {47'h0, done}, 48'h0);
      chk("zl_in_ready2", {47'h0, in_ready}, 48'h0);
      in_valid = 1'b0;
      cfg_valid = 1'b1; cfg_sparse = 1'b0; cfg_len = 16'd5;
      tick(); cfg_valid = 1'b0; in_valid = 1'b1; in_data = 48'd8;
      tick(); out_ready = 1'b0; in_valid = 1'b0; in_data = '0; rst = 1'b1; #1;
      chk("rs_pending", out_data, 48'd8);
      tick(); rst = 1'b0; #1;
      chk("rs_out_valid", {47'h0, out_valid}, 48'h0);
      chk("rs_out_data", out_data, 48'h0);
      chk("rs_busy", {47'h0, busy}, 48'h0);
      chk("rs_cfg_ready", {47'h0, cfg_ready}, 48'h1);
      chk("rs_err", {47'h0, err_protocol}, 48'h0);
   endtask

   initial begin
      test_reset();
      test_dense();
      test_sparse_pairs();
      test_protocol_error();
      test_back_to_back();
      test_abort();
      test_zero_len_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
